issue_scoreboard: RTL and testbench

Register-hazard scoreboard for the five-stage MIPS pipeline. It sits between Decode and Execute and drives `iss_stall` to Fetch and Decode. It tracks which architectural registers have a write in flight and stalls issue on RAW and WAW hazards. Pending bits are cleared by Writeback, and a per-register watchdog flags writes that never retire.

---
 rtl/mips_pkg.sv | 6 +
 rtl/sb_entry.sv | 28 ++
 rtl/issue_scoreboard.sv | 53 +++++
 tb/tb_issue_scoreboard.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared register-index type and pipeline defaults for the MIPS core
package mips_pkg;
  typedef logic [4:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam int WB_LAT_DFLT = 3;
endpackage

// File: rtl/sb_entry.sv
// sb_entry: one register's pending bit and its writeback watchdog
module sb_entry #(
  parameter int CNT_W = 4,
  parameter int LOAD = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic set,
  input  logic clr,
  input  logic tick,
  output logic pending,
  output logic expire
);
  logic [CNT_W-1:0] wd;
  assign expire = pending & tick & (wd == CNT_W'(1));
  // set outranks clear/expiry so a fresh issue is never lost
  always_ff @(posedge clock)
    if (reset) begin
      pending <= 1'b0;
      wd <= '0;
    end else if (set) begin
      pending <= 1'b1;
      wd <= CNT_W'(LOAD);
    end else if (clr | expire) begin
      pending <= 1'b0;
      wd <= '0;
    end else if (tick & pending) wd <= wd - CNT_W'(1);
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: RAW/WAW register-hazard scoreboard between Decode and Execute
module issue_scoreboard
  import mips_pkg::*;
#(
  parameter int WB_LAT = WB_LAT_DFLT,
  parameter int WD_SLACK = 4,
  parameter int CNT_W = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_iss_valid,
  input  logic [4:0]  id_iss_addra,
  input  logic [4:0]  id_iss_addrb,
  input  logic        id_iss_regdest,
  input  logic [4:0]  id_iss_dest,
  input  logic        id_iss_writereg,
  input  logic        ex_if_stall,
  input  logic        wb_reg_en,
  input  logic [4:0]  wb_reg_addr,
  output logic        iss_stall,
  output logic [31:0] iss_pending,
  output logic        iss_err,
  output logic [15:0] iss_stall_cnt
);
  logic [31:0] expire;
  logic raw, waw, fire;
  // r0 has no entry, so any lookup of it reads 0
  assign iss_pending[REG_ZERO] = 1'b0;
  assign expire[REG_ZERO] = 1'b0;
  assign raw = iss_pending[id_iss_addra] | (id_iss_regdest & iss_pending[id_iss_addrb]);
  assign waw = id_iss_writereg & iss_pending[id_iss_dest];
  assign iss_stall = id_iss_valid & (raw | waw);
  assign fire = id_iss_valid & ~iss_stall & ~ex_if_stall;
  for (genvar i = 1; i < 32; i++) begin : g_entry
    sb_entry #(.CNT_W(CNT_W), .LOAD(WB_LAT + WD_SLACK)) u_entry (
      .clock   (clock),
      .reset   (reset),
      .set     (fire & id_iss_writereg & (id_iss_dest == reg_idx_t'(i))),
      .clr     (wb_reg_en & (wb_reg_addr == reg_idx_t'(i))),
      .tick    (~ex_if_stall),
      .pending (iss_pending[i]),
      .expire  (expire[i])
    );
  end
  always_ff @(posedge clock)
    if (reset) begin
      iss_err <= 1'b0;
      iss_stall_cnt <= '0;
    end else begin
      if (|expire) iss_err <= 1'b1;
      if (iss_stall && !(&iss_stall_cnt)) iss_stall_cnt <= iss_stall_cnt + 16'd1;
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed checks of hazard stalls, writeback clear and watchdog
module tb_issue_scoreboard;
  logic        clock = 1'b0;
  logic        reset;
  logic        id_iss_valid;
  logic [4:0]  id_iss_addra;
  logic [4:0]  id_iss_addrb;
  logic        id_iss_regdest;
  logic [4:0]  id_iss_dest;
  logic        id_iss_writereg;
  logic        ex_if_stall;
  logic        wb_reg_en;
  logic [4:0]  wb_reg_addr;
  logic        iss_stall;
  logic [31:0] iss_pending;
  logic        iss_err;
  logic [15:0] iss_stall_cnt;
  int checks = 0;
  int passed = 0;

  issue_scoreboard dut (
    .clock           (clock),
    .reset           (reset),
    .id_iss_valid    (id_iss_valid),
    .id_iss_addra    (id_iss_addra),
    .id_iss_addrb    (id_iss_addrb),
    .id_iss_regdest  (id_iss_regdest),
    .id_iss_dest     (id_iss_dest),
    .id_iss_writereg (id_iss_writereg),
    .ex_if_stall     (ex_if_stall),
    .wb_reg_en       (wb_reg_en),
    .wb_reg_addr     (wb_reg_addr),
    .iss_stall       (iss_stall),
    .iss_pending     (iss_pending),
    .iss_err         (iss_err),
    .iss_stall_cnt   (iss_stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                       input logic rd, input logic [4:0] d, input logic w);
    id_iss_valid = v;
    id_iss_addra = a;
    id_iss_addrb = b;
    id_iss_regdest = rd;
    id_iss_dest = d;
    id_iss_writereg = w;
  endtask

  task automatic wb(input logic en, input logic [4:0] r);
    wb_reg_en = en;
    wb_reg_addr = r;
  endtask

  initial begin
    reset = 1'b1;
    ex_if_stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    wb(0, 0);
    step();
    step();
    check("rst_pending", iss_pending, 0);
    check("rst_err", 32'(iss_err), 0);
    check("rst_cnt", 32'(iss_stall_cnt), 0);
    check("rst_stall", 32'(iss_stall), 0);
    reset = 1'b0;
    // add r3,r1,r2 then dependent sub r4,r3,r5
    drive(1, 1, 2, 1, 3, 1);
    #1 check("add_stall", 32'(iss_stall), 0);
    step();
    check("add_pending", iss_pending, 32'h8);
    drive(1, 3, 5, 1, 4, 1);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) wb(1, 3);
      #1 check("raw_stall", 32'(iss_stall), 1);
      step();
    end
    wb(0, 0);
    #1 check("raw_release", 32'(iss_stall), 0);
    check("raw_cnt", 32'(iss_stall_cnt), 3);
    check("raw_cleared", iss_pending, 0);
    step();
    check("sub_issued", iss_pending, 32'h10);
    drive(0, 0, 0, 0, 0, 0);
    wb(1, 4);
    step();
    wb(0, 0);
    check("sub_wb", iss_pending, 0);
    // same pair with Execute frozen for two cycles mid-flight
    drive(1, 1, 2, 1, 3, 1);
    step();
    drive(1, 3, 5, 1, 4, 1);
    for (int k = 0; k < 5; k++) begin
      ex_if_stall = (k == 1 || k == 2);
      if (k == 4) wb(1, 3);
      #1 check("exs_stall", 32'(iss_stall), 1);
      step();
    end
    ex_if_stall = 1'b0;
    wb(0, 0);
    #1 check("exs_release", 32'(iss_stall), 0);
    check("exs_cnt", 32'(iss_stall_cnt), 8);
    check("exs_err", 32'(iss_err), 0);
    step();
    check("exs_sub_issued", iss_pending, 32'h10);
    drive(0, 0, 0, 0, 0, 0);
    wb(1, 4);
    step();
    wb(0, 0);
    // r0 writer then r0 reader
    drive(1, 1, 2, 1, 0, 1);
    #1 check("r0_write_stall", 32'(iss_stall), 0);
    step();
    check("r0_pending", iss_pending, 0);
    drive(1, 0, 0, 1, 5, 0);
    #1 check("r0_read_stall", 32'(iss_stall), 0);
    step();
    check("r0_cnt", 32'(iss_stall_cnt), 8);
    // WAW on r7, plus a stray writeback to an idle register
    drive(1, 1, 2, 1, 7, 1);
    wb(1, 12);
    step();
    wb(0, 0);
    check("waw_first", iss_pending, 32'h80);
    drive(1, 10, 11, 1, 7, 1);
    #1 check("waw_stall0", 32'(iss_stall), 1);
    step();
    wb(1, 7);
    #1 check("waw_stall1", 32'(iss_stall), 1);
    step();
    wb(0, 0);
    #1 check("waw_release", 32'(iss_stall), 0);
    check("waw_cleared", iss_pending, 0);
    step();
    check("waw_second", iss_pending, 32'h80);
    drive(0, 0, 0, 0, 0, 0);
    wb(1, 7);
    step();
    wb(0, 0);
    check("waw_cnt", 32'(iss_stall_cnt), 10);
    check("waw_done", iss_pending, 0);
    // r9 never written back: watchdog expiry
    drive(1, 1, 2, 1, 9, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("wd_set", iss_pending, 32'h200);
    for (int k = 0; k < 6; k++) step();
    check("wd_still_pending", 32'(iss_pending[9]), 1);
    check("wd_no_err_yet", 32'(iss_err), 0);
    step();
    check("wd_expired", 32'(iss_pending[9]), 0);
    check("wd_err", 32'(iss_err), 1);
    drive(1, 1, 2, 1, 3, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("post_err_issue", iss_pending, 32'h8);
    wb(1, 3);
    step();
    wb(0, 0);
    check("post_err_wb", iss_pending, 0);
    check("err_sticky", 32'(iss_err), 1);
    // reset with a write in flight drops it silently
    drive(1, 1, 2, 1, 5, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("pre_reset_pending", iss_pending, 32'h20);
    reset = 1'b1;
    step();
    check("mid_rst_pending", iss_pending, 0);
    check("mid_rst_err", 32'(iss_err), 0);
    check("mid_rst_cnt", 32'(iss_stall_cnt), 0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check("post_rst_err", 32'(iss_err), 0);
    check("post_rst_pending", iss_pending, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
